la_program_sequencer: RTL and testbench
=======================================

Name: la_program_sequencer

Overview:
- Host-side driver for the core's logic-analyzer debug interface, acting as the initiator to the core's LA responder.
- Drives the core's la_data_in bus to load up to 16 instruction words into IRAM with core reset held, release reset, bit-bang a programmed number of core clocks, then sweep the register-file read port and stream captured values out over a valid/ready interface.
- Sits in the test/management domain next to the core and replaces manual LA poking.

Parameters:
- IRAM_DEPTH, 16, instruction slots loadable; index width 4.
- NUM_REGS, 32, registers dumped (indices 0..NUM_REGS-1).
- SETTLE_CYCLES, 2, host cycles between changing a select field and sampling la_data_out; minimum 1.
- DRAM_DUMP_DEPTH, 16, DRAM words dumped when LA_DRAM_DUMP_EN is defined.

Ports:
- clk  input  1  host clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin a sequence.
- num_words  input  5  words to load; latched at start; values above 16 clamp to 16; 0 skips load.
- run_cycles  input  16  core clocks to issue; latched at start; 0 skips run.
- busy  output  1  high from accepted start until DONE.
- done  output  1  high in DONE until next accepted start.
- word_valid  input  1  instruction word available.
- word_data  input  32  instruction word.
- word_ready  output  1  sequencer accepts word_data this cycle.
- dump_valid  output  1  dump_data valid.
- dump_ready  input  1  consumer accepts dump_data.
- dump_data  output  32  captured value.
- dump_index  output  8  register or DRAM index of dump_data.
- dump_src  output  1  0 = register file, 1 = DRAM.
- la_data_in  output  128  drives core LA inputs.
- la_oenb  output  128  constant all-zero.
- la_data_out  input  128  core LA outputs.

Behaviour:
- la_data_in field map:
  - [31:0] instruction data.
  - [35:32] IRAM index.
  - [36] IRAM write.
  - [44:37] DRAM select.
  - [49:45] register select.
  - [50] core rst_n.
  - [51] core clk.
  - [127:52] always 0.
- Reset (async):
  - la_data_in = 0, so core held in reset with core clk low.
  - busy, done, word_ready and dump_valid = 0; dump_data, dump_index and dump_src = 0.
  - FSM returns to IDLE.
- FSM states: IDLE, LOAD_WAIT, LOAD_HI, LOAD_LO, RELEASE, RUN_HI, RUN_LO, DUMP_SEL, DUMP_SETTLE, DUMP_OUT, DONE.
- start:
  - Accepted only in IDLE or DONE; ignored while busy.
  - On acceptance: latch num_words and run_cycles, set [50]=0, clear done, set busy, zero the index counter.
  - Go to LOAD_WAIT, or to RELEASE if num_words=0.
- LOAD_WAIT:
  - word_ready=1 only in this state.
  - On word_valid&&word_ready: [31:0]=word_data, [35:32]=index, [36]=1; go to LOAD_HI.
- LOAD_HI: [51]=1 for one cycle; go to LOAD_LO.
- LOAD_LO:
  - [51]=0 and [36]=0; increment index.
  - Return to LOAD_WAIT until index equals the clamped count, then go to RELEASE.
  - Cost per word: 3 cycles after handshake.
- RELEASE:
  - [50]=1 and [31:0] cleared; load cycle counter from run_cycles.
  - Go to RUN_HI, or to DUMP_SEL if run_cycles=0.
- RUN_HI / RUN_LO:
  - RUN_HI sets [51]=1; RUN_LO sets [51]=0 and decrements the counter.
  - Repeat until the counter reaches 0, so exactly run_cycles rising edges of [51].
  - Core rst_n stays 1 from here until the next start or reset.
- DUMP_SEL: [49:45]=index (index restarts at 0 on entry to the dump phase); go to DUMP_SETTLE.
- DUMP_SETTLE: wait SETTLE_CYCLES, then capture la_data_out[95:64] into dump_data with dump_index=index and dump_src=0.
- DUMP_OUT:
  - dump_valid=1; data, index and src stay stable until dump_ready.
  - On handshake: dump_valid=0 the next cycle; increment index.
  - Continue with the next DUMP_SEL; after NUM_REGS-1 go to DONE.
- DONE: busy=0, done=1; [51]=0 and [50]=1 held, so the core is frozen and readable.
- Boundaries:
  - word_valid or dump_ready asserted in the wrong state is ignored.
  - start is ignored while busy, including in the same cycle as a final handshake.
  - rst_n mid-operation aborts immediately to reset values; partial IRAM contents are left as written.

Optional Feature:
- Macro: LA_DRAM_DUMP_EN.
- Defined: after the register sweep, additionally sweep DRAM entries 0..DRAM_DUMP_DEPTH-1.
  - Each entry sets [44:37]=index, waits SETTLE_CYCLES and captures la_data_out[63:32].
  - Each is streamed with dump_src=1 and dump_index restarting at 0; DONE follows the last DRAM word.
- Undefined: [44:37] always 0, dump_src always 0, DONE follows the register sweep.

Test Plan:
- Reset with busy flows → la_data_in=0, busy=0, word_ready=0, dump_valid=0; start while busy ignored.
- start, num_words=3, words 0x00500093, 0x00A00113, 0x002081B3 → three pulses on [51] with [36]=1, indices 0,1,2, [50]=0 throughout.
- Same program, run_cycles=3 → exactly 3 [51] rising edges after [50] rises; dump yields x1=5, x2=10, x3=15, other registers 0, indices 0..31.
- num_words=20 → exactly 16 words accepted; num_words=0 and run_cycles=0 → straight to dump, 32 outputs.
- dump_ready held low 10 cycles on index 4 → dump_valid, dump_data and dump_index stable; no skipped or duplicated index.
- rst_n pulsed mid-RUN_HI → la_data_in=0 asynchronously, FSM in IDLE; new start runs a clean sequence.

Source files
------------

// File: rtl/la_program_sequencer.sv
// la_program_sequencer: host-side initiator for the core's logic-analyzer port.
// Loads instruction words into IRAM with the core held in reset, then releases
// reset and toggles a programmed number of core clocks. Finally it sweeps the
// register-file read port and streams each captured value over valid/ready.
// Optional build macro: LA_DRAM_DUMP_EN adds a DRAM sweep after the registers.
module la_program_sequencer #(
  parameter int IRAM_DEPTH      = 16,
  parameter int NUM_REGS        = 32,
  parameter int SETTLE_CYCLES   = 2,
  parameter int DRAM_DUMP_DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [4:0]   num_words,
  input  logic [15:0]  run_cycles,
  output logic         busy,
  output logic         done,
  input  logic         word_valid,
  input  logic [31:0]  word_data,
  output logic         word_ready,
  output logic         dump_valid,
  input  logic         dump_ready,
  output logic [31:0]  dump_data,
  output logic [7:0]   dump_index,
  output logic         dump_src,
  output logic [127:0] la_data_in,
  output logic [127:0] la_oenb,
  input  logic [127:0] la_data_out
);

  typedef enum logic [3:0] {
    IDLE, LOAD_WAIT, LOAD_HI, LOAD_LO, RELEASE, RUN_HI, RUN_LO,
    DUMP_SEL, DUMP_SETTLE, DUMP_OUT, DONE
  } state_e;

  localparam logic [4:0]  MaxWords   = 5'(IRAM_DEPTH);
  localparam logic [7:0]  LastReg    = 8'(NUM_REGS - 1);
  localparam logic [15:0] LastSettle = 16'(SETTLE_CYCLES - 1);

  state_e      state_q;
  logic [31:0] instr_q;
  logic [3:0]  iramIdx_q;
  logic        iramWe_q;
  logic [7:0]  dramSel_q;
  logic [4:0]  regSel_q;
  logic        coreRstN_q;
  logic        coreClk_q;
  logic [4:0]  numWords_q;
  logic [15:0] runCycles_q;
  logic [15:0] cycleCnt_q;
  logic [15:0] settleCnt_q;
  logic [7:0]  index_q;
  logic        busy_q;
  logic        done_q;
  logic        wordReady_q;
  logic        dumpValid_q;
  logic        dumpSrc_q;
  logic [31:0] dumpData_q;
  logic [7:0]  dumpIndex_q;

  logic [4:0]  numClamped;
  logic        startAccept;
  logic        phaseIsDram;
  logic        regEnd;
  logic        sweepEnd;
  logic        unusedLaBits;

  assign numClamped  = (num_words > MaxWords) ? MaxWords : num_words;
  assign startAccept = start && ((state_q == IDLE) || (state_q == DONE));

`ifdef LA_DRAM_DUMP_EN
  localparam logic [7:0] LastDram = 8'(DRAM_DUMP_DEPTH - 1);
  logic dramPhase_q;

  assign phaseIsDram  = dramPhase_q;
  assign regEnd       = !dramPhase_q && (index_q == LastReg);
  assign sweepEnd     = dramPhase_q && (index_q == LastDram);
  assign unusedLaBits = ^{la_data_out[127:96], la_data_out[31:0]};

  // Tracks whether the dump has moved past the register file into DRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dramPhase_q <= 1'b0;
    end else if (startAccept) begin
      dramPhase_q <= 1'b0;
    end else if ((state_q == DUMP_OUT) && dump_ready && regEnd) begin
      dramPhase_q <= 1'b1;
    end
  end
`else
  assign phaseIsDram  = 1'b0;
  assign regEnd       = 1'b0;
  assign sweepEnd     = (index_q == LastReg);
  assign unusedLaBits = ^{la_data_out[127:96], la_data_out[31:0]} ^ (DRAM_DUMP_DEPTH < 1);
`endif

  assign la_data_in = {76'd0, coreClk_q, coreRstN_q, regSel_q, dramSel_q,
                       iramWe_q, iramIdx_q, instr_q};
  assign la_oenb    = '0;
  assign busy       = busy_q;
  assign done       = done_q;
  assign word_ready = wordReady_q;
  assign dump_valid = dumpValid_q;
  assign dump_data  = dumpData_q;
  assign dump_index = dumpIndex_q;
  assign dump_src   = dumpSrc_q;

  // Sequencer FSM: load, release, run, dump; every LA field and output is registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      instr_q     <= '0;
      iramIdx_q   <= '0;
      iramWe_q    <= 1'b0;
      dramSel_q   <= '0;
      regSel_q    <= '0;
      coreRstN_q  <= 1'b0;
      coreClk_q   <= 1'b0;
      numWords_q  <= '0;
      runCycles_q <= '0;
      cycleCnt_q  <= '0;
      settleCnt_q <= '0;
      index_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wordReady_q <= 1'b0;
      dumpValid_q <= 1'b0;
      dumpSrc_q   <= 1'b0;
      dumpData_q  <= '0;
      dumpIndex_q <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            numWords_q  <= numClamped;
            runCycles_q <= run_cycles;
            coreRstN_q  <= 1'b0;
            coreClk_q   <= 1'b0;
            regSel_q    <= '0;
            dramSel_q   <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b1;
            index_q     <= '0;
            if (numClamped == 5'd0) begin
              state_q <= RELEASE;
            end else begin
              state_q     <= LOAD_WAIT;
              wordReady_q <= 1'b1;
            end
          end
        end
        LOAD_WAIT: begin
          if (word_valid && wordReady_q) begin
            instr_q     <= word_data;
            iramIdx_q   <= index_q[3:0];
            iramWe_q    <= 1'b1;
            wordReady_q <= 1'b0;
            state_q     <= LOAD_HI;
          end
        end
        LOAD_HI: begin
          coreClk_q <= 1'b1;
          state_q   <= LOAD_LO;
        end
        LOAD_LO: begin
          coreClk_q <= 1'b0;
          iramWe_q  <= 1'b0;
          index_q   <= index_q + 8'd1;
          if ((index_q + 8'd1) == {3'b000, numWords_q}) begin
            state_q <= RELEASE;
          end else begin
            state_q     <= LOAD_WAIT;
            wordReady_q <= 1'b1;
          end
        end
        RELEASE: begin
          coreRstN_q <= 1'b1;
          instr_q    <= '0;
          cycleCnt_q <= runCycles_q;
          index_q    <= '0;
          state_q    <= (runCycles_q == 16'd0) ? DUMP_SEL : RUN_HI;
        end
        RUN_HI: begin
          coreClk_q <= 1'b1;
          state_q   <= RUN_LO;
        end
        RUN_LO: begin
          coreClk_q  <= 1'b0;
          cycleCnt_q <= cycleCnt_q - 16'd1;
          state_q    <= (cycleCnt_q == 16'd1) ? DUMP_SEL : RUN_HI;
        end
        DUMP_SEL: begin
          if (phaseIsDram) begin
            dramSel_q <= index_q;
          end else begin
            regSel_q <= index_q[4:0];
          end
          settleCnt_q <= '0;
          state_q     <= DUMP_SETTLE;
        end
        DUMP_SETTLE: begin
          settleCnt_q <= settleCnt_q + 16'd1;
          if (settleCnt_q >= LastSettle) begin
            dumpData_q  <= phaseIsDram ? la_data_out[63:32] : la_data_out[95:64];
            dumpIndex_q <= index_q;
            dumpSrc_q   <= phaseIsDram;
            dumpValid_q <= 1'b1;
            state_q     <= DUMP_OUT;
          end
        end
        DUMP_OUT: begin
          if (dump_ready) begin
            dumpValid_q <= 1'b0;
            if (sweepEnd) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              index_q <= regEnd ? 8'd0 : (index_q + 8'd1);
              state_q <= DUMP_SEL;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_la_program_sequencer.sv
// tb_la_program_sequencer: drives la_program_sequencer against a small behavioural
// core (IRAM, register file, ADDI/ADD execution) attached to its LA bus.
// Expected dump values are hand-computed from each program and pushed to a
// scoreboard queue; a monitor pops and compares on every dump handshake.
module tb_la_program_sequencer;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [4:0]   num_words;
  logic [15:0]  run_cycles;
  logic         busy;
  logic         done;
  logic         word_valid;
  logic [31:0]  word_data;
  logic         word_ready;
  logic         dump_valid;
  logic         dump_ready;
  logic [31:0]  dump_data;
  logic [7:0]   dump_index;
  logic         dump_src;
  logic [127:0] la_data_in;
  logic [127:0] la_oenb;
  logic [127:0] la_data_out;

  typedef struct packed {
    logic        src;
    logic [7:0]  idx;
    logic [31:0] data;
  } dump_t;

  dump_t       expQ[$];
  logic [31:0] wordQ[$];
  logic [31:0] expRegs [32];
  int          errors = 0;
  int          checks = 0;

  la_program_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .num_words   (num_words),
    .run_cycles  (run_cycles),
    .busy        (busy),
    .done        (done),
    .word_valid  (word_valid),
    .word_data   (word_data),
    .word_ready  (word_ready),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_index  (dump_index),
    .dump_src    (dump_src),
    .la_data_in  (la_data_in),
    .la_oenb     (la_oenb),
    .la_data_out (la_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural core seen through the LA bus
  wire        laCoreClk  = la_data_in[51];
  wire        laCoreRstN = la_data_in[50];
  logic [31:0] iramM [16];
  logic [31:0] regsM [32] = '{default: '0};
  logic [3:0]  pcM = '0;
  int          loadPulses = 0;
  int          loadRstHigh = 0;
  int          runEdges = 0;

  function automatic logic [31:0] aluResult(input logic [31:0] inst, input logic [31:0] a,
                                            input logic [31:0] b);
    if (inst[6:0] == 7'h13) return a + {{20{inst[31]}}, inst[31:20]};
    return a + b;
  endfunction

  assign la_data_out = {32'h0, regsM[la_data_in[49:45]], 24'hD0D0D0, la_data_in[44:37], 32'h0};

  // IRAM writes happen on a core clock edge while the write strobe is set.
  always @(posedge laCoreClk) begin
    if (la_data_in[36]) iramM[la_data_in[35:32]] <= la_data_in[31:0];
  end

  // Core execution: one instruction per core clock edge once out of reset.
  always @(posedge laCoreClk or negedge laCoreRstN) begin
    if (!laCoreRstN) begin
      for (int i = 0; i < 32; i++) regsM[i] <= '0;
      pcM <= '0;
    end else begin
      if (((iramM[pcM][6:0] == 7'h13) || (iramM[pcM][6:0] == 7'h33)) &&
          (iramM[pcM][14:12] == 3'd0) && (iramM[pcM][11:7] != 5'd0))
        regsM[iramM[pcM][11:7]] <= aluResult(iramM[pcM], regsM[iramM[pcM][19:15]],
                                             regsM[iramM[pcM][24:20]]);
      pcM <= pcM + 4'd1;
    end
  end

  // Edge counters used to verify load pulses and run length.
  always @(posedge laCoreClk) begin
    if (la_data_in[36]) loadPulses <= loadPulses + 1;
    if (la_data_in[36] && laCoreRstN) loadRstHigh <= loadRstHigh + 1;
    if (laCoreRstN) runEdges <= runEdges + 1;
  end

  // Word source: presents queued words continuously, pops on handshake.
  initial begin
    word_valid = 1'b0;
    word_data  = '0;
    forever begin
      @(negedge clk);
      word_valid = (wordQ.size() > 0);
      word_data  = (wordQ.size() > 0) ? wordQ[0] : 32'h0;
      if (word_valid && word_ready) void'(wordQ.pop_front());
    end
  end

  // Dump consumer and scoreboard monitor, with a 10-cycle stall on register 4.
  dump_t       expD;
  int          stallCnt = 0;
  logic        holdActive = 1'b0;
  logic [31:0] heldData;
  logic [7:0]  heldIdx;
  logic        heldSrc;
  initial begin
    dump_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (holdActive) begin
        checks++;
        if (!dump_valid || dump_data !== heldData || dump_index !== heldIdx || dump_src !== heldSrc) begin
          errors++;
          $display("[TB] FAIL stall_stable: got v=%0b idx=%0d data=0x%08h, expected v=1 idx=%0d data=0x%08h",
                   dump_valid, dump_index, dump_data, heldIdx, heldData);
        end
      end
      if (dump_valid && !dump_src && dump_index == 8'd0) stallCnt = 0;
      if (dump_valid && !dump_src && dump_index == 8'd4 && stallCnt < 10) begin
        dump_ready = 1'b0;
        stallCnt++;
      end else begin
        dump_ready = 1'b1;
      end
      if (dump_valid && dump_ready) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_dump: got src=%0b idx=%0d data=0x%08h, expected none",
                   dump_src, dump_index, dump_data);
        end else begin
          expD = expQ.pop_front();
          if ({dump_src, dump_index, dump_data} !== expD) begin
            errors++;
            $display("[TB] FAIL dump_entry: got src=%0b idx=%0d data=0x%08h, expected src=%0b idx=%0d data=0x%08h",
                     dump_src, dump_index, dump_data, expD.src, expD.idx, expD.data);
          end
        end
      end
      holdActive = dump_valid && !dump_ready;
      heldData   = dump_data;
      heldIdx    = dump_index;
      heldSrc    = dump_src;
    end
  end

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int nw, input int rc);
    @(negedge clk);
    num_words  = 5'(nw);
    run_cycles = 16'(rc);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic pushDumps();
    for (int i = 0; i < 32; i++) expQ.push_back({1'b0, 8'(i), expRegs[i]});
`ifdef LA_DRAM_DUMP_EN
    for (int i = 0; i < 16; i++) expQ.push_back({1'b1, 8'(i), 24'hD0D0D0, 8'(i)});
`endif
  endtask

  task automatic setRegs(input int r1, input logic [31:0] v1, input int r2, input logic [31:0] v2,
                         input int r3, input logic [31:0] v3);
    for (int i = 0; i < 32; i++) expRegs[i] = '0;
    expRegs[r1] = v1;
    expRegs[r2] = v2;
    expRegs[r3] = v3;
  endtask

  task automatic waitDone(input string name, input int budget);
    int n = 0;
    while (!(done && !busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, {126'd0, done, busy}, 128'h2);
  endtask

  task automatic pushProgramA();
    wordQ.push_back(32'h00500093);
    wordQ.push_back(32'h00A00113);
    wordQ.push_back(32'h002081B3);
  endtask

  int baseLoad;
  int baseRun;
  int baseRstHigh;
  int n;

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    run_cycles = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_la_data_in", la_data_in, 128'h0);
    checkOutput("reset_flags", {124'd0, busy, done, word_ready, dump_valid}, 128'h0);
    checkOutput("reset_dump_regs", {87'd0, dump_src, dump_index, dump_data}, 128'h0);
    checkOutput("la_oenb_zero", la_oenb, 128'h0);
    rst_n = 1'b1;

    // Program A: three words, three core clocks; start during load ignored
    $display("[TB] program A: load 3, run 3");
    pushProgramA();
    setRegs(1, 32'd5, 2, 32'd10, 3, 32'd15);
    pushDumps();
    baseLoad = loadPulses; baseRun = runEdges; baseRstHigh = loadRstHigh;
    applyStimulus(3, 3);
    repeat (2) @(negedge clk);
    checkOutput("busy_after_start", {127'd0, busy}, 128'h1);
    num_words = 5'd1; run_cycles = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone("done_program_a", 2000);
    checkOutput("load_pulses_a", 128'(loadPulses - baseLoad), 128'd3);
    checkOutput("load_rst_low_a", 128'(loadRstHigh - baseRstHigh), 128'd0);
    checkOutput("run_edges_a", 128'(runEdges - baseRun), 128'd3);
    checkOutput("iram0_a", {96'd0, iramM[0]}, {96'd0, 32'h00500093});
    checkOutput("iram1_a", {96'd0, iramM[1]}, {96'd0, 32'h00A00113});
    checkOutput("iram2_a", {96'd0, iramM[2]}, {96'd0, 32'h002081B3});
    checkOutput("done_la_fields_a", {126'd0, la_data_in[51:50]}, 128'h1);
    checkOutput("word_ready_idle_a", {127'd0, word_ready}, 128'h0);

    // Program C: num_words=20 clamps to 16; run_cycles=0 goes straight to dump
    $display("[TB] program C: load 20 (clamped), run 0");
    wordQ.push_back(32'h00700213);
    wordQ.push_back(32'h00120293);
    for (int i = 0; i < 14; i++) wordQ.push_back(32'h00000013);
    for (int i = 0; i < 4; i++) wordQ.push_back(32'hDEADBEEF);
    setRegs(0, 32'd0, 0, 32'd0, 0, 32'd0);
    pushDumps();
    baseLoad = loadPulses; baseRun = runEdges;
    applyStimulus(20, 0);
    waitDone("done_program_c", 3000);
    checkOutput("load_pulses_c", 128'(loadPulses - baseLoad), 128'd16);
    checkOutput("run_edges_c", 128'(runEdges - baseRun), 128'd0);
    checkOutput("words_left_c", 128'(wordQ.size()), 128'd4);
    checkOutput("iram0_c", {96'd0, iramM[0]}, {96'd0, 32'h00700213});
    checkOutput("iram15_c", {96'd0, iramM[15]}, {96'd0, 32'h00000013});
    wordQ.delete();

    // Program D: no load, run 3 from retained IRAM; start on final handshake ignored
    $display("[TB] program D: load 0, run 3");
    setRegs(4, 32'd7, 5, 32'd8, 0, 32'd0);
    pushDumps();
    baseLoad = loadPulses; baseRun = runEdges;
    applyStimulus(0, 3);
    n = 0;
    while (!(dump_valid && dump_index == 8'd31 && !dump_src) && n < 2000) begin
      @(negedge clk);
      n++;
    end
`ifdef LA_DRAM_DUMP_EN
    n = 0;
    while (!(dump_valid && dump_index == 8'd15 && dump_src) && n < 2000) begin
      @(negedge clk);
      n++;
    end
`endif
    checkOutput("reached_last_dump_d", {127'd0, dump_valid}, 128'h1);
    num_words = 5'd3; run_cycles = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_on_last_ignored", {126'd0, done, busy}, 128'h2);
    checkOutput("load_pulses_d", 128'(loadPulses - baseLoad), 128'd0);
    checkOutput("run_edges_d", 128'(runEdges - baseRun), 128'd3);

    // Abort: reset while the core clock is being toggled
    $display("[TB] abort: reset during run");
    applyStimulus(0, 200);
    n = 0;
    while (!(la_data_in[51] && la_data_in[50]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reached_run_phase", {126'd0, la_data_in[51:50]}, 128'h3);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("abort_la_data_in", la_data_in, 128'h0);
    checkOutput("abort_flags", {123'd0, busy, done, word_ready, dump_valid, dump_src}, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program F: clean sequence after abort
    $display("[TB] program F: load 3, run 3 after abort");
    pushProgramA();
    setRegs(1, 32'd5, 2, 32'd10, 3, 32'd15);
    pushDumps();
    baseLoad = loadPulses; baseRun = runEdges;
    applyStimulus(3, 3);
    waitDone("done_program_f", 2000);
    checkOutput("load_pulses_f", 128'(loadPulses - baseLoad), 128'd3);
    checkOutput("run_edges_f", 128'(runEdges - baseRun), 128'd3);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 128'(expQ.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
